// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO for ALU results (value, opcode, flags) with sticky flag
// accumulation and a saturating overflow counter.
module alu_result_buffer #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_out,
   input  logic [1:0] in_select,
   input  logic [4:0] in_flags,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic [1:0] out_select,
   output logic [4:0] out_flags,
   output logic [3:0] count,
   output logic       full,
   output logic       empty,
   output logic [4:0] sticky_flags,
   input  logic       sticky_clr,
   output logic [7:0] ovf_count
);

   localparam int         PTR_W   = $clog2(DEPTH);
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   // Entry packing: {value[10:7], opcode[6:5], flags[4:0]}
   logic [10:0]      mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [3:0]       count_r;
   logic [3:0]       count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic [4:0]       sticky_r;
   logic [4:0]       sticky_nxt_s;
   logic [7:0]       ovf_r;
   logic [7:0]       ovf_nxt_s;
   logic             push_s;
   logic             pop_s;

   // Handshakes use only registered status, so in_ready never sees out_ready.
   assign push_s = in_valid & ~full_r;
   assign pop_s  = out_ready & ~empty_r;

   assign in_ready     = ~full_r;
   assign out_valid    = ~empty_r;
   assign full         = full_r;
   assign empty        = empty_r;
   assign count        = count_r;
   assign sticky_flags = sticky_r;
   assign ovf_count    = ovf_r;
   assign {out_data, out_select, out_flags} = mem_r[rd_ptr_r];

   // Next occupancy, sticky flags and overflow count.
   always_comb begin
      count_nxt_s  = count_r;
      sticky_nxt_s = sticky_r;
      ovf_nxt_s    = ovf_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + 4'd1;
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - 4'd1;
      end else begin
         count_nxt_s = count_r;
      end
      if (sticky_clr) begin
         sticky_nxt_s = push_s ? in_flags : 5'd0;
      end else if (push_s) begin
         sticky_nxt_s = sticky_r | in_flags;
      end else begin
         sticky_nxt_s = sticky_r;
      end
      if (push_s && in_flags[4] && (ovf_r != 8'hFF)) begin
         ovf_nxt_s = ovf_r + 8'd1;
      end else begin
         ovf_nxt_s = ovf_r;
      end
   end

   // Storage, pointers and status registers; reset also clears storage so the
   // head reads zero until the first push.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 11'd0;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= 4'd0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         sticky_r <= 5'd0;
         ovf_r    <= 8'd0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {in_out, in_select, in_flags};
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r  <= count_nxt_s;
         full_r   <= (count_nxt_s == DEPTH_C);
         empty_r  <= (count_nxt_s == 4'd0);
         sticky_r <= sticky_nxt_s;
         ovf_r    <= ovf_nxt_s;
      end
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_out;
   logic [1:0] in_select;
   logic [4:0] in_flags;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [1:0] out_select;
   logic [4:0] out_flags;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic [4:0] sticky_flags;
   logic       sticky_clr;
   logic [7:0] ovf_count;

   alu_result_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_out(in_out), .in_select(in_select), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_select(out_select), .out_flags(out_flags),
      .count(count), .full(full), .empty(empty),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
      .ovf_count(ovf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: entries as {value, opcode, flags}
   logic [10:0] q[$];
   logic [4:0]  m_sticky;
   int          m_ovf;
   bit          m_zero_head;
   int          vec_cnt;
   int          err_cnt;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_sticky    = 5'd0;
      m_ovf       = 0;
      m_zero_head = 1'b1;
   endtask

   task automatic check_state();
      check_val("count", 32'(count), 32'(q.size()));
      check_val("full", 32'(full), 32'(q.size() == DEPTH));
      check_val("empty", 32'(empty), 32'(q.size() == 0));
      check_val("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      check_val("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check_val("sticky", 32'(sticky_flags), 32'(m_sticky));
      check_val("ovf_count", 32'(ovf_count), 32'(m_ovf));
      if (q.size() > 0) begin
         check_val("head", 32'({out_data, out_select, out_flags}), 32'(q[0]));
      end else if (m_zero_head) begin
         check_val("head_rst", 32'({out_data, out_select, out_flags}), 32'd0);
      end
   endtask

   // One clock: drive inputs, check pre-edge state, then advance the model.
   task automatic cycle(input logic v, input logic r, input logic [3:0] d,
                        input logic [1:0] s, input logic [4:0] f,
                        input logic clr, input logic rs);
      bit do_push;
      bit do_pop;
      in_valid   = v;
      out_ready  = r;
      in_out     = d;
      in_select  = s;
      in_flags   = f;
      sticky_clr = clr;
      rst        = rs;
      #1;
      check_state();
      @(posedge clk);
      if (rs) begin
         model_reset();
      end else begin
         do_push = v && (q.size() < DEPTH);
         do_pop  = r && (q.size() > 0);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back({d, s, f});
            m_zero_head = 1'b0;
            if (f[4] && m_ovf < 255) m_ovf = m_ovf + 1;
         end
         if (clr) m_sticky = do_push ? f : 5'd0;
         else if (do_push) m_sticky = m_sticky | f;
      end
      @(negedge clk);
   endtask

   task automatic push_only(input logic [3:0] d, input logic [4:0] f);
      cycle(1'b1, 1'b0, d, 2'b00, f, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_out = 4'd0;
      in_select = 2'b00; in_flags = 5'd0; sticky_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Single entry round trip, first push right after reset release
      cycle(1'b1, 1'b0, 4'd7, 2'b00, 5'b00000, 1'b0, 1'b0);
      check_val("s032_data", 32'(out_data), 32'd7);
      cycle(1'b0, 1'b1, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      check_val("s032_empty", 32'(empty), 32'd1);

      // Fill to full, refused push, refused push with concurrent pop, drain
      for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 4'(i), 2'(i), 5'd0, 1'b0, 1'b0);
      check_val("s033_full", 32'(full), 32'd1);
      push_only(4'd9, 5'd0);
      cycle(1'b1, 1'b1, 4'd9, 2'b11, 5'd0, 1'b0, 1'b0);
      check_val("s033_cnt", 32'(count), 32'd3);
      for (int i = 2; i <= 4; i++) begin
         check_val("s033_order", 32'(out_data), 32'(i));
         cycle(1'b0, 1'b1, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      end

      // Steady push+pop at count 2 across pointer wrap
      push_only(4'hA, 5'd0);
      push_only(4'hB, 5'd0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'(i), 2'b01, 5'd0, 1'b0, 1'b0);
      check_val("s034_cnt", 32'(count), 32'd2);

      // Sticky flags and clear-with-push
      cycle(1'b1, 1'b1, 4'd1, 2'b10, 5'b00001, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 4'd2, 2'b10, 5'b10000, 1'b0, 1'b0);
      check_val("s035_sticky", 32'(sticky_flags), 32'h11);
      cycle(1'b1, 1'b1, 4'd3, 2'b11, 5'b00100, 1'b1, 1'b0);
      check_val("s035_clr", 32'(sticky_flags), 32'h04);
      cycle(1'b0, 1'b0, 4'd0, 2'b00, 5'd0, 1'b1, 1'b0);

      // Overflow counter saturation
      for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 4'(i), 2'b10, 5'b10000, 1'b0, 1'b0);
      check_val("s036_sat", 32'(ovf_count), 32'd255);

      // Reset with entries held beats simultaneous push, pop and clear
      idle();
      while (q.size() > 3) cycle(1'b0, 1'b1, 4'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      while (q.size() < 3) push_only(4'd5, 5'b11111);
      cycle(1'b1, 1'b1, 4'd6, 2'b01, 5'b10000, 1'b1, 1'b1);
      check_val("s037_cnt", 32'(count), 32'd0);
      push_only(4'd8, 5'b10010);
      idle();

      // Randomized traffic with varying valid/ready densities
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) <= ph),
                  1'($urandom_range(0, 3) >= ph),
                  4'($urandom), 2'($urandom), 5'($urandom),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 199) == 0));
         end
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
